// File: rtl/video_mnist_argmax.sv
// Per-beat class vote popcount, argmax and threshold detection for the MNIST LUT-CNN stream.
// Three lock-step register stages share one enable that freezes the whole pipe on output back-pressure.
module video_mnist_argmax #(
  parameter int TUSER_WIDTH = 1,
  parameter int NUM_CLASS   = 10,
  parameter int CHANNEL_NUM = 8,
  parameter int CLASS_WIDTH = 4,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                             reset,
  input  logic                             clk,
  input  logic [COUNT_WIDTH-1:0]           param_threshold,
  input  logic [TUSER_WIDTH-1:0]           s_axi4s_tuser,
  input  logic                             s_axi4s_tlast,
  input  logic [NUM_CLASS*CHANNEL_NUM-1:0] s_axi4s_tdata,
  input  logic                             s_axi4s_tvalid,
  output logic                             s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]           m_axi4s_tuser,
  output logic                             m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]           m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]           m_axi4s_tcount,
  output logic                             m_axi4s_tdetect,
  output logic                             m_axi4s_tvalid,
  input  logic                             m_axi4s_tready
);

  localparam int HALF = NUM_CLASS / 2;

  logic                            cke;
  logic                            st1_valid_reg, st2_valid_reg, st3_valid_reg;
  logic [TUSER_WIDTH-1:0]          st1_user_reg, st2_user_reg, st3_user_reg;
  logic                            st1_last_reg, st2_last_reg, st3_last_reg;
  logic [NUM_CLASS*COUNT_WIDTH-1:0] st1_count_flat;
  logic [2*CLASS_WIDTH-1:0]        st2_idx_flat;
  logic [2*COUNT_WIDTH-1:0]        st2_cnt_flat;
  logic [CLASS_WIDTH-1:0]          st3_class_reg, win_class_next;
  logic [COUNT_WIDTH-1:0]          st3_count_reg, win_count_next;
  logic                            st3_detect_reg;

  // Only a held, unaccepted output beat stalls the pipe; bubbles still advance.
  assign cke            = ~(st3_valid_reg & ~m_axi4s_tready);
  assign s_axi4s_tready = cke;

  genvar gi;

  // ST1: one popcount per class group.
  generate
    for (gi = 0; gi < NUM_CLASS; gi++) begin : g_popcount
      logic [COUNT_WIDTH-1:0] count_next;
      logic [COUNT_WIDTH-1:0] count_reg;

      always_comb begin
        count_next = '0;
        for (int b = 0; b < CHANNEL_NUM; b++) begin
          count_next = count_next + COUNT_WIDTH'(s_axi4s_tdata[gi*CHANNEL_NUM + b]);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg <= '0;
        end else if (cke) begin
          count_reg <= count_next;
        end
      end

      assign st1_count_flat[gi*COUNT_WIDTH +: COUNT_WIDTH] = count_reg;
    end
  endgenerate

  // ST2: independent argmax over the lower and upper halves of the class range.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      localparam int LO = (gi == 0) ? 0 : HALF;
      localparam int HI = (gi == 0) ? HALF : NUM_CLASS;
      logic [CLASS_WIDTH-1:0] idx_next, idx_reg;
      logic [COUNT_WIDTH-1:0] cnt_next, cnt_reg;

      // Strict greater-than keeps the lowest index on ties.
      always_comb begin
        idx_next = CLASS_WIDTH'(LO);
        cnt_next = st1_count_flat[LO*COUNT_WIDTH +: COUNT_WIDTH];
        for (int i = LO + 1; i < HI; i++) begin
          if (st1_count_flat[i*COUNT_WIDTH +: COUNT_WIDTH] > cnt_next) begin
            idx_next = CLASS_WIDTH'(i);
            cnt_next = st1_count_flat[i*COUNT_WIDTH +: COUNT_WIDTH];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          idx_reg <= '0;
          cnt_reg <= '0;
        end else if (cke) begin
          idx_reg <= idx_next;
          cnt_reg <= cnt_next;
        end
      end

      assign st2_idx_flat[gi*CLASS_WIDTH +: CLASS_WIDTH] = idx_reg;
      assign st2_cnt_flat[gi*COUNT_WIDTH +: COUNT_WIDTH] = cnt_reg;
    end
  endgenerate

  // ST3: upper half wins only when strictly larger, so ties resolve to the lower index.
  always_comb begin
    win_class_next = st2_idx_flat[0 +: CLASS_WIDTH];
    win_count_next = st2_cnt_flat[0 +: COUNT_WIDTH];
    if (st2_cnt_flat[COUNT_WIDTH +: COUNT_WIDTH] > st2_cnt_flat[0 +: COUNT_WIDTH]) begin
      win_class_next = st2_idx_flat[CLASS_WIDTH +: CLASS_WIDTH];
      win_count_next = st2_cnt_flat[COUNT_WIDTH +: COUNT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st1_valid_reg  <= 1'b0;
      st2_valid_reg  <= 1'b0;
      st3_valid_reg  <= 1'b0;
      st1_user_reg   <= '0;
      st2_user_reg   <= '0;
      st3_user_reg   <= '0;
      st1_last_reg   <= 1'b0;
      st2_last_reg   <= 1'b0;
      st3_last_reg   <= 1'b0;
      st3_class_reg  <= '0;
      st3_count_reg  <= '0;
      st3_detect_reg <= 1'b0;
    end else if (cke) begin
      st1_valid_reg  <= s_axi4s_tvalid;
      st2_valid_reg  <= st1_valid_reg;
      st3_valid_reg  <= st2_valid_reg;
      st1_user_reg   <= s_axi4s_tuser;
      st2_user_reg   <= st1_user_reg;
      st3_user_reg   <= st2_user_reg;
      st1_last_reg   <= s_axi4s_tlast;
      st2_last_reg   <= st1_last_reg;
      st3_last_reg   <= st2_last_reg;
      st3_class_reg  <= win_class_next;
      st3_count_reg  <= win_count_next;
      st3_detect_reg <= (win_count_next >= param_threshold);
    end
  end

  assign m_axi4s_tuser   = st3_user_reg;
  assign m_axi4s_tlast   = st3_last_reg;
  assign m_axi4s_tclass  = st3_class_reg;
  assign m_axi4s_tcount  = st3_count_reg;
  assign m_axi4s_tdetect = st3_detect_reg;
  assign m_axi4s_tvalid  = st3_valid_reg;

endmodule
